// File: rtl/display_channel_scheduler.sv
// display_channel_scheduler
// Chooses which of four sensor channels the 4-digit seven-segment display
// shows. Channels rotate round-robin with a fixed dwell time. Alarmed
// channels preempt the rotation, and the lowest index wins. The chosen
// reading is saturated to 9999 and converted to BCD by a sequential
// shift-add-3 (double-dabble) engine, one bit per cycle.
// Optional build macro: DISP_ALARM_BLINK_EN makes the display blink while an
// alarmed channel is shown.
// Output handshake: bcd_valid is a one-cycle strobe that marks a new value on
// bcd/disp_ch. There is no ready and no backpressure; the consumer takes the
// value in that cycle. bcd and disp_ch then hold until the next strobe.
// The FSM state register (state_q) is a named, typed signal so checkers can
// bind to it directly.
module display_channel_scheduler #(
  parameter int unsigned DWELL_CYCLES = 100_000_000,
  parameter int unsigned BLINK_CYCLES = 25_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] ch0_val,
  input  logic [13:0] ch1_val,
  input  logic [13:0] ch2_val,
  input  logic [13:0] ch3_val,
  input  logic [3:0]  ch_valid,
  input  logic [3:0]  alarm,
  output logic [15:0] bcd,
  output logic        bcd_valid,
  output logic [1:0]  disp_ch,
  output logic        alarm_active,
  output logic        blank
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SELECT  = 3'd1,
    S_CONVERT = 3'd2,
    S_LOAD    = 3'd3,
    S_HOLD    = 3'd4
  } state_t;

  localparam int unsigned DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

  state_t             state_q;
  state_t             state_d;
  logic [13:0]        ch_vals [4];
  logic [3:0]         alarmed;
  logic               sel_found;
  logic [1:0]         sel_next;
  logic [1:0]         cand;
  logic [13:0]        snap_val;
  logic [3:0]         own_mask;
  logic [3:0]         lower_mask;
  logic               preempt;
  logic               hold_exit;
  logic [15:0]        adj;
  logic [1:0]         sel_ch;
  logic [13:0]        bin_sr;
  logic [15:0]        bcd_acc;
  logic [3:0]         bit_cnt;
  logic [DWELL_W-1:0] dwell_cnt;

`ifdef DISP_ALARM_BLINK_EN
  localparam int unsigned BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);
  logic [BLINK_W-1:0] blink_cnt;
`else
  // Without the blink feature BLINK_CYCLES has no effect on the hardware.
  if (BLINK_CYCLES == 0) begin : g_blink_cycles_unused
  end
`endif

  assign ch_vals[0] = ch0_val;
  assign ch_vals[1] = ch1_val;
  assign ch_vals[2] = ch2_val;
  assign ch_vals[3] = ch3_val;

  // Channel choice: lowest alarmed valid channel, else next valid after disp_ch.
  always_comb begin
    alarmed   = alarm & ch_valid;
    sel_found = 1'b0;
    sel_next  = disp_ch;
    cand      = disp_ch;
    if (alarmed != 4'b0000) begin
      sel_found = 1'b1;
      for (int i = 3; i >= 0; i--) begin
        if (alarmed[i]) sel_next = 2'(i);
      end
    end else begin
      // Offset 4 wraps to disp_ch itself, so the sole valid channel is reselected.
      for (int k = 4; k >= 1; k--) begin
        cand = disp_ch + 2'(k);
        if (ch_valid[cand]) begin
          sel_found = 1'b1;
          sel_next  = cand;
        end
      end
    end
    snap_val = (ch_vals[sel_next] > 14'd9999) ? 14'd9999 : ch_vals[sel_next];
  end

  // HOLD exit: dwell expiry, shown channel invalidated, or alarm preemption.
  always_comb begin
    own_mask   = 4'b0001 << disp_ch;
    lower_mask = own_mask - 4'd1;
    preempt    = alarm_active ? ((alarmed & lower_mask) != 4'b0000)
                              : ((alarmed & ~own_mask) != 4'b0000);
    hold_exit  = (dwell_cnt == DWELL_LAST) || !ch_valid[disp_ch] || preempt;
  end

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
  always_comb begin
    adj = bcd_acc;
    for (int n = 0; n < 4; n++) begin
      if (bcd_acc[4*n +: 4] >= 4'd5) adj[4*n +: 4] = bcd_acc[4*n +: 4] + 4'd3;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (ch_valid != 4'b0000) state_d = S_SELECT;
      S_SELECT:  state_d = sel_found ? S_CONVERT : S_IDLE;
      S_CONVERT: if (bit_cnt == 4'd13) state_d = S_LOAD;
      S_LOAD:    state_d = S_HOLD;
      S_HOLD:    if (hold_exit) state_d = S_SELECT;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath and registered outputs, sequenced by the FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_ch       <= 2'd0;
      bin_sr       <= 14'd0;
      bcd_acc      <= 16'd0;
      bit_cnt      <= 4'd0;
      dwell_cnt    <= '0;
      bcd          <= 16'd0;
      bcd_valid    <= 1'b0;
      disp_ch      <= 2'd0;
      alarm_active <= 1'b0;
      blank        <= 1'b1;
`ifdef DISP_ALARM_BLINK_EN
      blink_cnt    <= '0;
`endif
    end else begin
      bcd_valid <= 1'b0;
      case (state_q)
        S_SELECT: begin
          if (sel_found) begin
            sel_ch       <= sel_next;
            bin_sr       <= snap_val;
            bcd_acc      <= 16'd0;
            bit_cnt      <= 4'd0;
            alarm_active <= alarm[sel_next];
          end else begin
            blank <= 1'b1;
          end
        end
        S_CONVERT: begin
          bcd_acc <= (adj << 1) | {15'd0, bin_sr[13]};
          bin_sr  <= bin_sr << 1;
          bit_cnt <= bit_cnt + 4'd1;
        end
        S_LOAD: begin
          bcd       <= bcd_acc;
          disp_ch   <= sel_ch;
          bcd_valid <= 1'b1;
          blank     <= 1'b0;
          dwell_cnt <= '0;
`ifdef DISP_ALARM_BLINK_EN
          blink_cnt <= '0;
`endif
        end
        S_HOLD: begin
          if (!hold_exit) dwell_cnt <= dwell_cnt + 1'b1;
`ifdef DISP_ALARM_BLINK_EN
          if (alarm_active) begin
            if (hold_exit) begin
              blank <= 1'b0;
            end else if (blink_cnt == BLINK_LAST) begin
              blank     <= ~blank;
              blink_cnt <= '0;
            end else begin
              blink_cnt <= blink_cnt + 1'b1;
            end
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_display_channel_scheduler.sv
// tb_display_channel_scheduler
// Directed scenarios (reset, rotation, saturation, preemption, valid drop)
// followed by randomized channel/alarm/value traffic with a mid-run reset.
// A transaction-level reference model predicts every output on every cycle.
module tb_display_channel_scheduler;

  localparam int DWELL = 20;
  localparam int BLINK = 5;

  localparam int M_IDLE = 0;
  localparam int M_PICK = 1;
  localparam int M_BUSY = 2;
  localparam int M_SHOW = 3;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] ch0_val = '0, ch1_val = '0, ch2_val = '0, ch3_val = '0;
  logic [3:0]  ch_valid = '0;
  logic [3:0]  alarm = '0;
  logic [15:0] bcd;
  logic        bcd_valid;
  logic [1:0]  disp_ch;
  logic        alarm_active;
  logic        blank;

  always #5 clk = ~clk;

  display_channel_scheduler #(
    .DWELL_CYCLES(DWELL),
    .BLINK_CYCLES(BLINK)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ch0_val(ch0_val),
    .ch1_val(ch1_val),
    .ch2_val(ch2_val),
    .ch3_val(ch3_val),
    .ch_valid(ch_valid),
    .alarm(alarm),
    .bcd(bcd),
    .bcd_valid(bcd_valid),
    .disp_ch(disp_ch),
    .alarm_active(alarm_active),
    .blank(blank)
  );

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  bit chk_en = 1'b0;

  // ---------------- reference model ----------------
  int          m_mode = M_IDLE;
  logic [15:0] m_bcd = '0;
  logic        m_bcd_valid = 1'b0;
  int          m_disp = 0;
  logic        m_act = 1'b0;
  logic        m_blank = 1'b1;
  int          m_held = 0;
  int          m_left = 0;
  int          m_ch = 0;
  int          m_val = 0;

  function automatic int val_of(input int c);
    case (c)
      0:       return int'(ch0_val);
      1:       return int'(ch1_val);
      2:       return int'(ch2_val);
      default: return int'(ch3_val);
    endcase
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Lowest alarmed valid channel, else next valid after cur (cur itself last).
  function automatic int pick(input logic [3:0] v, input logic [3:0] a, input int cur);
    for (int i = 0; i < 4; i++) if (v[i] && a[i]) return i;
    for (int k = 1; k <= 4; k++) if (v[(cur + k) % 4]) return (cur + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_bcd = '0; m_bcd_valid = 1'b0; m_disp = 0;
    m_act = 1'b0; m_blank = 1'b1; m_held = 0; m_left = 0;
  endtask

  task automatic model_step();
    int c;
    bit leave, lower_alarm, other_alarm;
    m_bcd_valid = 1'b0;
    case (m_mode)
      M_IDLE: if (ch_valid != 4'b0) m_mode = M_PICK;
      M_PICK: begin
        c = pick(ch_valid, alarm, m_disp);
        if (c < 0) begin
          m_mode = M_IDLE;
          m_blank = 1'b1;
        end else begin
          m_ch = c;
          m_val = (val_of(c) > 9999) ? 9999 : val_of(c);
          m_act = alarm[c];
          m_left = 15;  // 14 conversion cycles + 1 load cycle
          m_mode = M_BUSY;
        end
      end
      M_BUSY: begin
        m_left--;
        if (m_left == 0) begin
          m_bcd = to_bcd(m_val);
          m_disp = m_ch;
          m_bcd_valid = 1'b1;
          m_blank = 1'b0;
          m_held = 0;
          m_mode = M_SHOW;
        end
      end
      default: begin
        lower_alarm = 1'b0;
        other_alarm = 1'b0;
        for (int j = 0; j < 4; j++) begin
          if (alarm[j] && ch_valid[j]) begin
            if (j < m_disp) lower_alarm = 1'b1;
            if (j != m_disp) other_alarm = 1'b1;
          end
        end
        leave = (m_held == DWELL - 1) || !ch_valid[m_disp] ||
                (m_act ? lower_alarm : other_alarm);
        if (leave) begin
          m_mode = M_PICK;
`ifdef DISP_ALARM_BLINK_EN
          if (m_act) m_blank = 1'b0;
`endif
        end else begin
          m_held++;
`ifdef DISP_ALARM_BLINK_EN
          if (m_act && (m_held % BLINK) == 0) m_blank = !m_blank;
`endif
        end
      end
    endcase
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // ---------------- scoreboard / compare ----------------
  task automatic compare_cycle();
    checks++;
    if (bcd_valid === 1'b1) pulse_cnt++;
    if (bcd !== m_bcd || bcd_valid !== m_bcd_valid || disp_ch !== 2'(m_disp) ||
        alarm_active !== m_act || blank !== m_blank) begin
      errors++;
      $display("FAIL model_cmp t=%0t bcd=%h exp %h valid=%b exp %b disp=%0d exp %0d act=%b exp %b blank=%b exp %b",
               $time, bcd, m_bcd, bcd_valid, m_bcd_valid, disp_ch, m_disp[1:0],
               alarm_active, m_act, blank, m_blank);
    end
  endtask

  always @(negedge clk) if (chk_en) compare_cycle();

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Waits (bounded) for the next bcd_valid strobe; n = cycles waited.
  task automatic wait_load(input int budget, output int n);
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (bcd_valid === 1'b1) return;
    end
    checks++;
    errors++;
    $display("FAIL load_timeout: no bcd_valid within %0d cycles", budget);
    n = -1;
  endtask

  task automatic rand_value(output logic [13:0] v);
    case ($urandom_range(0, 4))
      0:       v = 14'd9999;
      1:       v = 14'd10000;
      2:       v = 14'd16383;
      default: v = 14'($urandom_range(0, 16383));
    endcase
  endtask

  logic [15:0] exp_bcd_tab [4] = '{16'h1234, 16'h5678, 16'h0042, 16'h9999};
  int          rot_seq [5] = '{1, 2, 3, 0, 1};

  initial begin
    int n;
    int p0;
    logic [13:0] rv;

    // Reset state with no valid channels.
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset_bcd", 32'(bcd), 32'h0);
    check("reset_blank", 32'(blank), 32'h1);
    #1 rst_n = 1'b1;
    p0 = pulse_cnt;
    repeat (1000) @(negedge clk);
    check("idle_no_pulses", 32'(pulse_cnt - p0), 32'h0);
    check("idle_blank", 32'(blank), 32'h1);
    check("idle_bcd", 32'(bcd), 32'h0);

    // Rotation through all four channels.
    #1;
    ch0_val = 14'd1234; ch1_val = 14'd5678; ch2_val = 14'd42; ch3_val = 14'd9999;
    ch_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_load(200, n);
      check("rot_disp", 32'(disp_ch), 32'(rot_seq[i]));
      check("rot_bcd", 32'(bcd), 32'(exp_bcd_tab[rot_seq[i]]));
      if (i > 0) check("rot_spacing", 32'(n), 32'd36);
    end
    check("model_pin_bcd", 32'(m_bcd), 32'h5678);

    // Saturation with only ch0 valid.
    #1 ch0_val = 14'd16383; ch_valid = 4'b0001;
    wait_load(200, n);
    for (int i = 0; i < 2; i++) begin
      wait_load(200, n);
      check("sat_bcd", 32'(bcd), 32'h9999);
      check("sat_disp", 32'(disp_ch), 32'h0);
      check("sat_spacing", 32'(n), 32'd36);
    end

    // Preemption: ch0 in HOLD, alarm on ch2, then on ch1.
    #1 ch0_val = 14'd1234;
    wait_load(200, n);
    repeat (3) @(negedge clk);
    #1 ch_valid = 4'b1111; alarm = 4'b0100;
    wait_load(100, n);
    check("pre2_latency", 32'(n), 32'd17);
    check("pre2_disp", 32'(disp_ch), 32'h2);
    check("pre2_act", 32'(alarm_active), 32'h1);
    check("pre2_bcd", 32'(bcd), 32'h0042);
    check("pre2_blank0", 32'(blank), 32'h0);
    check("model_pin_act", 32'(m_act), 32'h1);
    repeat (6) @(negedge clk);
`ifdef DISP_ALARM_BLINK_EN
    check("blink_on", 32'(blank), 32'h1);
`else
    check("blink_off", 32'(blank), 32'h0);
`endif
    #1 alarm = 4'b0110;
    wait_load(100, n);
    check("pre1_latency", 32'(n), 32'd17);
    check("pre1_disp", 32'(disp_ch), 32'h1);
    check("pre1_act", 32'(alarm_active), 32'h1);
    check("pre1_bcd", 32'(bcd), 32'h5678);
    #1 alarm = 4'b0000;
    wait_load(100, n);
    check("clr_spacing", 32'(n), 32'd36);
    check("clr_disp", 32'(disp_ch), 32'h2);
    check("clr_act", 32'(alarm_active), 32'h0);

    // Valid drop of the shown channel, then of everything.
    repeat (4) @(negedge clk);
    #1 ch_valid = 4'b1011;
    wait_load(100, n);
    check("drop_latency", 32'(n), 32'd17);
    check("drop_disp", 32'(disp_ch), 32'h3);
    repeat (2) @(negedge clk);
    #1 ch_valid = 4'b0000;
    p0 = pulse_cnt;
    repeat (50) @(negedge clk);
    check("all_drop_blank", 32'(blank), 32'h1);
    check("all_drop_pulses", 32'(pulse_cnt - p0), 32'h0);

    // Randomized traffic with one reset in the middle.
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      #1;
      if ($urandom_range(0, 39) == 0) ch_valid = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 59) == 0) alarm = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) begin
        rand_value(rv);
        case ($urandom_range(0, 3))
          0:       ch0_val = rv;
          1:       ch1_val = rv;
          2:       ch2_val = rv;
          default: ch3_val = rv;
        endcase
      end
      if (i == 3000) begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_bcd", 32'(bcd), 32'h0);
        check("midrst_blank", 32'(blank), 32'h1);
        check("midrst_disp", 32'(disp_ch), 32'h0);
        #1 rst_n = 1'b1;
      end
    end

    // ---------------- final report ----------------
    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
